ahb_sram_subordinate: RTL and testbench
=======================================

// Module: ahb_sram_subordinate
// PURPOSE
//  AHB subordinate (responder) terminating the ahb_if manager-side signals in an on-chip SRAM.
//  Answers HREADYOUT/HRESP/HRDATA. Supports a fixed number of wait states per transfer.
//  Gives the two-cycle ERROR response for illegal transfers.
//  Used as the default memory target for the AHB UVM environment and for system integration.
// PARAMETERS
//  BUS_WIDTH    32   HADDR width
//  DATA_WIDTH   32   HWDATA/HRDATA width; legal values 32 or 64
//  MEM_DEPTH    256  memory size in DATA_WIDTH words
//  WAIT_STATES  0    wait cycles inserted in every OKAY data phase (0..15)
// PORTS
//  HCLK       in   1           bus clock; all state changes on the rising edge
//  HRESET     in   1           asynchronous, active-high reset
//  HSELx      in   1           subordinate select from the decoder
//  HADDR      in   BUS_WIDTH   transfer address (address phase)
//  HTRANS     in   2           IDLE/BUSY/NONSEQ/SEQ
//  HWRITE     in   1           1=write, 0=read
//  HSIZE      in   3           transfer size, in bytes = 2**HSIZE
//  HBURST     in   3           burst type; accepted, no effect on behaviour
//  HPROT      in   7           protection; accepted, no effect on behaviour
//  HWDATA     in   DATA_WIDTH  write data (data phase)
//  HREADY     in   1           bus-wide ready from the response mux
//  HRDATA     out  DATA_WIDTH  read data
//  HREADYOUT  out  1           this subordinate's ready
//  HRESP      out  1           0=OKAY, 1=ERROR
// BEHAVIOUR
//  - Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, all pending data-phase regs cleared.
//    Memory contents are not reset.
//  - Transfer accept: on an edge with HSELx & HREADY & HTRANS[1]. NONSEQ and SEQ are treated identically.
//    The block registers addr_q, write_q, size_q and err_q.
//  - IDLE or BUSY with HSELx=1: zero-wait OKAY; no state change.
//  - Transfer is illegal (err_q=1) when any of these holds:
//    - HADDR >= MEM_DEPTH*DATA_WIDTH/8
//    - 2**HSIZE > DATA_WIDTH/8
//    - HADDR is not aligned to HSIZE
//  - FSM states: IDLE, DATA, ERR1, ERR2. The wait counter wcnt is 4 bits.
//    - IDLE: HREADYOUT=1, HRESP=0. On accept: err -> ERR1; else -> DATA with wcnt=WAIT_STATES.
//    - DATA: HREADYOUT=(wcnt==0), HRESP=0.
//      - While wcnt>0: wcnt decrements each cycle.
//      - When wcnt==0 the data phase ends this cycle. On accept -> ERR1 or DATA as from IDLE; else -> IDLE.
//    - ERR1: HREADYOUT=0, HRESP=1; unconditionally -> ERR2.
//    - ERR2: HREADYOUT=1, HRESP=1; next state as from IDLE. A new transfer may be accepted here.
//  - Write commit: at the edge ending a DATA phase (wcnt==0) with write_q=1.
//    - Byte lanes addr_q[lsb..0]..+2**size_q-1 of mem[addr_q/(DATA_WIDTH/8)] take HWDATA; little-endian.
//    - Other lanes are unchanged.
//  - Read data:
//    - In a DATA phase with write_q=0: HRDATA = mem[word(addr_q)], full word on all lanes.
//    - Otherwise HRDATA=0.
//  - Latency: read data is valid in the cycle after the address phase plus WAIT_STATES cycles.
//  - Write then read of the same address, back-to-back: the read returns the new data, because the write
//    commits on the edge that starts the read data phase.
//  - Errored transfers never modify memory; their HRDATA is 0.
//  - HREADY=0 while idle (another subordinate is stalling): nothing is sampled and there is no state change.
//  - HSELx deasserted mid data phase: the pending phase still completes normally.
//  - HRESET asserted mid transfer: immediate return to IDLE; a pending write is dropped.
// STRUCTURE
//  - ahb_pkg (shared):
//    - htrans_e: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
//    - hsize_e: BYTE=0, HALF=1, WORD=2, DWORD=3
//    - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1
//    - sram_state_e: IDLE, DATA, ERR1, ERR2
//  - Sub-module ahb_strb_gen: combinational (addr lsbs, hsize) -> byte-lane strobe plus misalign flag.
//    Reused by future AHB subordinates.
// TESTING
//  - Reset: assert HRESET for 3 cycles with random inputs -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
//  - Word write/read, WAIT_STATES=0: NONSEQ write 0x10 with 0xDEADBEEF, then NONSEQ read 0x10 back-to-back
//    -> read data phase HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0.
//  - Byte write, 32-bit bus: write 0x00 with 0x11223344, then HSIZE=BYTE write 0x02 with HWDATA=0x00AA0000,
//    then read 0x00 -> 0x11AA3344.
//  - Wait states, WAIT_STATES=2: read 0x04 -> HREADYOUT low for exactly 2 cycles, high with valid data
//    on the 3rd cycle.
//  - Error response, MEM_DEPTH=256: write 0x400, or HSIZE=HALF at 0x01 -> {HREADYOUT=0,HRESP=1},
//    then {1,1}; memory unchanged; next read OKAY.
//  - Gating: HTRANS=IDLE/BUSY, HSELx=0, or HREADY=0 during the address phase -> no memory change,
//    HREADYOUT stays 1.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM subordinate state type.
// Reused by every AHB subordinate in this slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator: (address lsbs, HSIZE) -> little-endian lane mask,
// plus flags for a misaligned address and a transfer wider than the bus.
module ahb_strb_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_addr,
  input  logic [2:0]                      i_size,
  output logic [DATA_WIDTH/8-1:0]         o_strb,
  output logic                            o_misalign,
  output logic                            o_oversize
);

  localparam int NB = DATA_WIDTH / 8;

  logic [8:0] w_nbytes;
  logic [7:0] w_mask;
  logic [8:0] w_lo;

  always_comb begin
    w_nbytes   = 9'd1 << i_size;
    w_mask     = 8'(w_nbytes - 9'd1);
    w_lo       = 9'(i_addr);
    o_misalign = |(8'(i_addr) & w_mask);
    o_oversize = (w_nbytes > 9'(NB));
    o_strb     = '0;
    for (int i = 0; i < NB; i++) begin
      o_strb[i] = (9'(i) >= w_lo) && (9'(i) < w_lo + w_nbytes);
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate backed by an on-chip SRAM: fixed wait states on OKAY data
// phases, two-cycle ERROR response for out-of-range/oversize/misaligned transfers.
module ahb_sram_subordinate #(
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELx,
  input  logic [BUS_WIDTH-1:0]  HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [6:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  import ahb_pkg::*;

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LSB_W     = $clog2(NB);
  localparam int WORD_AW   = $clog2(MEM_DEPTH);
  localparam int BYTE_AW   = WORD_AW + LSB_W;
  localparam int MEM_BYTES = MEM_DEPTH * NB;

  sram_state_e           r_state, w_next_state;
  logic [3:0]            r_wcnt, w_next_wcnt;
  logic [BYTE_AW-1:0]    r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic          w_accept, w_phase_end, w_err, w_oor, w_misalign, w_oversize, w_commit;
  logic [NB-1:0] w_strb, w_unused_chk_strb;
  logic          w_unused_wr_misalign, w_unused_wr_oversize, w_unused_ports;

  assign w_unused_ports = ^{HBURST, HPROT};
  assign w_accept       = HSELx & HREADY & HTRANS[1];
  assign w_oor          = (HADDR >= BUS_WIDTH'(MEM_BYTES));
  assign w_err          = w_oor | w_misalign | w_oversize;

  // Address-phase legality check; the second instance drives the write lanes.
  ahb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_chk (
    .i_addr     (HADDR[LSB_W-1:0]),
    .i_size     (HSIZE),
    .o_strb     (w_unused_chk_strb),
    .o_misalign (w_misalign),
    .o_oversize (w_oversize)
  );

  ahb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_wr (
    .i_addr     (r_addr[LSB_W-1:0]),
    .i_size     (r_size),
    .o_strb     (w_strb),
    .o_misalign (w_unused_wr_misalign),
    .o_oversize (w_unused_wr_oversize)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_wcnt  = r_wcnt;
    w_phase_end  = 1'b0;
    HREADYOUT    = 1'b1;
    HRESP        = HRESP_OKAY;
    case (r_state)
      ST_IDLE: w_phase_end = 1'b1;
      ST_DATA: begin
        HREADYOUT = (r_wcnt == 4'd0);
        if (r_wcnt != 4'd0) w_next_wcnt = r_wcnt - 4'd1;
        else                w_phase_end = 1'b1;
      end
      ST_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = HRESP_ERROR;
        w_next_state = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = HRESP_ERROR;
        w_phase_end = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Whenever the current phase is finishing, the next one comes from the bus.
    if (w_phase_end) begin
      if (w_accept) begin
        w_next_state = w_err ? ST_ERR1 : ST_DATA;
        w_next_wcnt  = 4'(WAIT_STATES);
      end else begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wcnt  <= w_next_wcnt;
      if (w_phase_end && w_accept) begin
        r_addr  <= HADDR[BYTE_AW-1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_err   <= w_err;
      end
    end
  end

  assign w_commit = (r_state == ST_DATA) && (r_wcnt == 4'd0) && r_write && !r_err;

  // Memory contents deliberately survive reset.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb[i]) r_mem[r_addr[BYTE_AW-1:LSB_W]][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (r_state == ST_DATA && !r_write) HRDATA = r_mem[r_addr[BYTE_AW-1:LSB_W]];
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: a zero-wait and a two-wait SRAM subordinate share one bus;
// HREADY is the AND of both HREADYOUTs, as the response mux would give.
module tb_ahb_sram_subordinate;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel0, hsel1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [6:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY, hreadyLow;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1, hresp0, hresp1;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] rd;
  logic        fr, rs;
  int          wt;

  assign HREADY = hreadyLow ? 1'b0 : (hreadyout0 & hreadyout1);

  always #5 HCLK = ~HCLK;

  ahb_sram_subordinate #(.BUS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
  );

  ahb_sram_subordinate #(.BUS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  // tgt: 0 selects u_dut0, 1 selects u_dut1, anything else selects neither.
  task automatic applyStimulus(input int tgt, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    hsel0  = (tgt == 0);
    hsel1  = (tgt == 1);
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HWDATA = wdata;
  endtask

  task automatic transfer(input int tgt, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic firstResp,
                          output logic resp, output int waits);
    logic rdy;
    applyStimulus(tgt, HT_NONSEQ, wr, addr, size, 32'h0);
    nextCycle();
    HTRANS    = HT_IDLE;
    HWDATA    = wdata;
    firstResp = (tgt == 1) ? hresp1 : hresp0;
    waits     = 0;
    rdy       = (tgt == 1) ? hreadyout1 : hreadyout0;
    while (!rdy && waits < 20) begin
      waits++;
      nextCycle();
      rdy = (tgt == 1) ? hreadyout1 : hreadyout0;
    end
    if (waits >= 20) checkOutput("ready_timeout", {63'h0, rdy}, 64'h1);
    rdata = (tgt == 1) ? hrdata1 : hrdata0;
    resp  = (tgt == 1) ? hresp1 : hresp0;
    nextCycle();
  endtask

  // An address phase that must not be accepted: write of 0 to 0x10 on u_dut0.
  task automatic gateCheck(input string tag, input int tgt, input logic [1:0] trans, input logic forceLow);
    applyStimulus(tgt, trans, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
    hreadyLow = forceLow;
    nextCycle();
    checkOutput(tag, {62'h0, hreadyout0, hresp0}, {62'h0, 1'b1, 1'b0});
    hreadyLow = 1'b0;
    HTRANS    = HT_IDLE;
    nextCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESET    = 1'b0;
    hreadyLow = 1'b0;
    HBURST    = 3'd0;
    HPROT     = 7'd0;
    applyStimulus(2, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    #2 HRESET = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(int'($urandom_range(0, 2)), 2'($urandom), 1'($urandom), $urandom, 3'($urandom), $urandom);
      HBURST = 3'($urandom);
      HPROT  = 7'($urandom);
      nextCycle();
      checkOutput("reset_dut0", {30'h0, hreadyout0, hresp0, hrdata0}, {30'h0, 1'b1, 1'b0, 32'h0});
      checkOutput("reset_dut1", {30'h0, hreadyout1, hresp1, hrdata1}, {30'h0, 1'b1, 1'b0, 32'h0});
    end
    applyStimulus(2, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    HRESET = 1'b0;
    nextCycle();

    // Write then read of 0x10, pipelined back-to-back.
    applyStimulus(0, HT_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h0);
    nextCycle();
    checkOutput("b2b_wr_ready", {63'h0, hreadyout0}, 64'h1);
    HWDATA = 32'hDEADBEEF;
    HWRITE = 1'b0;
    nextCycle();
    checkOutput("b2b_rd_data", hrdata0, 32'hDEADBEEF);
    checkOutput("b2b_rd_ready_resp", {62'h0, hreadyout0, hresp0}, {62'h0, 1'b1, 1'b0});
    HTRANS = HT_IDLE;
    nextCycle();
    checkOutput("b2b_idle_rdata", hrdata0, 32'h0);

    // Sub-word writes merge into the existing word.
    transfer(0, 1'b1, 32'h00, HSIZE_WORD, 32'h11223344, rd, fr, rs, wt);
    transfer(0, 1'b1, 32'h02, HSIZE_BYTE, 32'h00AA0000, rd, fr, rs, wt);
    checkOutput("byte_wr_resp", {63'h0, rs}, 64'h0);
    transfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("byte_merge", rd, 32'h11AA3344);
    transfer(0, 1'b1, 32'h04, HSIZE_WORD, 32'h55667788, rd, fr, rs, wt);
    transfer(0, 1'b1, 32'h06, HSIZE_HALF, 32'hBEEF0000, rd, fr, rs, wt);
    transfer(0, 1'b0, 32'h04, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("half_merge", rd, 32'hBEEF7788);

    // Two wait states on u_dut1.
    transfer(1, 1'b1, 32'h04, HSIZE_WORD, 32'hCAFEF00D, rd, fr, rs, wt);
    checkOutput("ws_wr_waits", 64'(wt), 64'd2);
    transfer(1, 1'b0, 32'h04, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("ws_rd_waits", 64'(wt), 64'd2);
    checkOutput("ws_rd_data", rd, 32'hCAFEF00D);
    checkOutput("ws_rd_resp", {63'h0, rs}, 64'h0);

    // Illegal transfers: two-cycle ERROR, memory untouched.
    transfer(0, 1'b1, 32'h400, HSIZE_WORD, 32'hFFFFFFFF, rd, fr, rs, wt);
    checkOutput("err_oor_resp", {61'h0, fr, rs, wt[1:0]}, {61'h0, 1'b1, 1'b1, 2'd1});
    checkOutput("err_oor_rdata", rd, 32'h0);
    transfer(0, 1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, rd, fr, rs, wt);
    checkOutput("err_misalign_resp", {61'h0, fr, rs, wt[1:0]}, {61'h0, 1'b1, 1'b1, 2'd1});
    transfer(0, 1'b1, 32'h08, HSIZE_DWORD, 32'hFFFFFFFF, rd, fr, rs, wt);
    checkOutput("err_oversize_resp", {61'h0, fr, rs, wt[1:0]}, {61'h0, 1'b1, 1'b1, 2'd1});
    transfer(1, 1'b0, 32'h402, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("err_ws_resp", {61'h0, fr, rs, wt[1:0]}, {61'h0, 1'b1, 1'b1, 2'd1});
    transfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("err_mem_intact", rd, 32'h11AA3344);
    checkOutput("err_next_okay", {63'h0, rs}, 64'h0);

    // Gated address phases never write.
    gateCheck("gate_idle",   0, HT_IDLE,   1'b0);
    gateCheck("gate_busy",   0, HT_BUSY,   1'b0);
    gateCheck("gate_nosel",  2, HT_NONSEQ, 1'b0);
    gateCheck("gate_hready", 0, HT_NONSEQ, 1'b1);
    transfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("gate_mem_intact", rd, 32'hDEADBEEF);

    // Reset during a pending write drops it.
    transfer(1, 1'b1, 32'h20, HSIZE_WORD, 32'hAAAA5555, rd, fr, rs, wt);
    applyStimulus(1, HT_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h0);
    nextCycle();
    HTRANS = HT_IDLE;
    HWDATA = 32'h12345678;
    checkOutput("rst_mid_wait", {63'h0, hreadyout1}, 64'h0);
    HRESET = 1'b1;
    #1;
    checkOutput("rst_mid_ready", {63'h0, hreadyout1}, 64'h1);
    nextCycle();
    HRESET = 1'b0;
    nextCycle();
    transfer(1, 1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, fr, rs, wt);
    checkOutput("rst_mid_dropped", rd, 32'hAAAA5555);

    $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
